// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / redirect controller.
package pipe_hazard_ctrl_pkg;

  // Per-unit multi-cycle sequencer state
  typedef enum logic [1:0] {
    MCU_IDLE = 2'd0,
    MCU_BUSY = 2'd1,
    MCU_DONE = 2'd2
  } mcu_state_e;

  // Redirect target for every exception code other than ERET
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
  // Exception code in MEM that means ERET (target is the current EPC)
  localparam logic [31:0] ERET_CODE_DEFAULT  = 32'h0000000E;

  // Bit positions in ex_mcu_req / mcu_ready
  localparam int MCU_DIV = 0;
  localparam int MCU_MUL = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_mcu_seq.sv
// Single multi-cycle unit sequencer: start / busy / done handshake with abort.
module mcu_seq
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,      // this unit is the one serviced for the EX instruction
  input  logic ready,    // unit result valid (level)
  input  logic exc,      // exception in MEM: abandon whatever is in flight
  input  logic hold,     // MEM is stalled, EX instruction cannot leave yet
  output logic start,
  output logic cancel,
  output logic waiting   // EX must be held for this unit
);

  mcu_state_e state, state_nxt;

  // State register
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MCU_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_nxt = state;
    start     = 1'b0;
    cancel    = 1'b0;
    waiting   = 1'b0;
    case (state)
      MCU_IDLE: begin
        if (req) begin
          waiting = 1'b1;
          // An exception in the same cycle suppresses the start; nothing to cancel.
          if (!exc) begin
            start     = 1'b1;
            state_nxt = MCU_BUSY;
          end
        end
      end
      MCU_BUSY: begin
        waiting = 1'b1;
        if (exc) begin
          cancel    = 1'b1;
          state_nxt = MCU_IDLE;
        end else if (ready) begin
          // Even if ready was already high at start, one BUSY cycle is spent here.
          state_nxt = MCU_DONE;
        end
      end
      MCU_DONE: begin
        // The EX instruction advances in the first cycle MEM is not stalled.
        if (exc || !hold) state_nxt = MCU_IDLE;
      end
      default: state_nxt = MCU_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush generation, multi-cycle unit sequencing and redirect holding
// for the 5-stage core.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int          N_MCU      = 2,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_rmem,
  input  logic [4:0]       ex_wa,
  input  logic [N_MCU-1:0] ex_mcu_req,
  input  logic [N_MCU-1:0] mcu_ready,
  output logic [N_MCU-1:0] mcu_start,
  output logic [N_MCU-1:0] mcu_cancel,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      mem_excepttype,
  input  logic [31:0]      mem_cp0_epc,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic             wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  logic             lu;
  logic             exc;
  logic [31:0]      exc_target;
  logic [N_MCU-1:0] mcu_sel;
  logic [N_MCU-1:0] unit_wait;
  logic             mcu_wait;
  logic             rp_v;
  logic [31:0]      rp_pc;
  logic             front_stall;
  logic             ex_stall_raw;
  logic             redirect_flush;

  // Load in EX feeding a source of the instruction in ID; $0 never hazards.
  assign lu = ex_rmem && (ex_wa != 5'd0) && ((ex_wa == id_rs) || (ex_wa == id_rt));

  assign exc        = |mem_excepttype;
  assign exc_target = (mem_excepttype == ERET_CODE) ? mem_cp0_epc : EXC_VECTOR;

  // Only the lowest requested unit is serviced: isolate the lowest set bit.
  assign mcu_sel = ex_mcu_req & (~ex_mcu_req + N_MCU'(1));

  for (genvar g = 0; g < N_MCU; g++) begin : g_mcu
    mcu_seq u_seq (
      .clk     (clk),
      .rst     (rst),
      .req     (mcu_sel[g]),
      .ready   (mcu_ready[g]),
      .exc     (exc),
      .hold    (stallreq_from_mem),
      .start   (mcu_start[g]),
      .cancel  (mcu_cancel[g]),
      .waiting (unit_wait[g])
    );
  end

  assign mcu_wait = |(mcu_sel & unit_wait);

  // Hold a redirect until fetch can accept it; a newer exception overwrites the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_v  <= 1'b0;
      rp_pc <= 32'd0;
    end else if (exc && stallreq_from_if) begin
      rp_v  <= 1'b1;
      rp_pc <= exc_target;
    end else if (!stallreq_from_if) begin
      rp_v  <= 1'b0;
    end
  end

  assign redirect_valid = exc | rp_v;
  assign redirect_pc    = exc ? exc_target : rp_pc;

  // Raw stall conditions before flush priority is applied.
  assign front_stall    = lu | mcu_wait | stallreq_from_if | stallreq_from_mem;
  assign ex_stall_raw   = mcu_wait | stallreq_from_mem;
  assign redirect_flush = exc | rp_v;

  // A load-use bubble goes into EX only when EX itself is moving.
  assign if_flush  = redirect_flush;
  assign id_flush  = redirect_flush;
  assign ex_flush  = redirect_flush | (lu & ~ex_stall_raw);
  assign mem_flush = redirect_flush;
  assign wb_flush  = exc | stallreq_from_mem;

  // Flush wins over stall in every stage.
  assign if_stall  = front_stall       & ~if_flush;
  assign id_stall  = front_stall       & ~id_flush;
  assign ex_stall  = ex_stall_raw      & ~ex_flush;
  assign mem_stall = stallreq_from_mem & ~mem_flush;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and redirect controller for the 5-stage MIPS core. It generates per-stage stall and flush signals. It sequences up to `N_MCU` multi-cycle execute units (divider, multiplier, ...) through a per-unit start/busy/done handshake. It also holds exception/ERET redirects until fetch can accept them. It sits beside the datapath: it takes register indices and requests from ID/EX/MEM and drives the stall/flush enables of every pipeline register.

## Interface
Parameters:
- `N_MCU`, 2, number of multi-cycle EX units (1..8)
- `EXC_VECTOR`, 32'hBFC00380, redirect target for every non-ERET exception code
- `ERET_CODE`, 32'h0000000E, `mem_excepttype` value meaning ERET (target = `mem_cp0_epc`)

Ports:
- `clk` in 1 — clock
- `rst` in 1 — reset, asynchronous, active-high
- `id_rs`, `id_rt` in 5 — source registers of the instruction in ID
- `ex_rmem` in 1 — instruction in EX is a load
- `ex_wa` in 5 — destination register of the instruction in EX
- `ex_mcu_req` in N_MCU — instruction in EX needs unit i
- `mcu_ready` in N_MCU — unit i result valid (level)
- `mcu_start` out N_MCU — one-cycle start pulse to unit i
- `mcu_cancel` out N_MCU — one-cycle abort pulse to unit i
- `stallreq_from_if`, `stallreq_from_mem` in 1 — memory-interface stall requests
- `mem_excepttype` in 32 — exception code in MEM; 0 means none
- `mem_cp0_epc` in 32 — current EPC
- `if_stall`, `id_stall`, `ex_stall`, `mem_stall` out 1 — hold stage register
- `if_flush`, `id_flush`, `ex_flush`, `mem_flush`, `wb_flush` out 1 — clear stage register
- `redirect_valid` out 1 — `redirect_pc` must be loaded into PC
- `redirect_pc` out 32 — redirect target

## Operation
- Load-use: `lu = ex_rmem & (ex_wa != 0) & (ex_wa == id_rs | ex_wa == id_rt)`. Register $0 never causes a stall.
- Per-unit FSM: IDLE, BUSY, DONE. If several `ex_mcu_req` bits are set, only the lowest index is serviced.
  - IDLE → BUSY when `ex_mcu_req[i]` is set and no exception is present; `mcu_start[i]` pulses in this cycle.
  - BUSY → DONE on `mcu_ready[i]`.
  - DONE → IDLE in the first cycle with `!stallreq_from_mem`; the EX instruction advances in that cycle.
  - Any state → IDLE on an exception; `mcu_cancel[i]` pulses if the unit was BUSY.
- `mcu_wait` = the serviced unit is in IDLE (with a request) or BUSY.
- Exception: `exc = (mem_excepttype != 0)`. The target is `mem_cp0_epc` when the code equals `ERET_CODE`, otherwise `EXC_VECTOR`.
- Redirect pending register `rp_v`/`rp_pc`:
  - Set on `exc & stallreq_from_if`.
  - Cleared in the first cycle with `!stallreq_from_if`.
  - A new `exc` while pending overwrites `rp_pc`.
- `redirect_valid = exc | rp_v`. `redirect_pc` = the current-cycle target if `exc`, else `rp_pc`.
- Stalls:
  - `if_stall = id_stall = lu | mcu_wait | stallreq_from_if | stallreq_from_mem`
  - `ex_stall = mcu_wait | stallreq_from_mem`
  - `mem_stall = stallreq_from_mem`
- Flushes:
  - `if_flush = id_flush = mem_flush = exc | rp_v`
  - `ex_flush = exc | rp_v | (lu & !ex_stall)`
  - `wb_flush = exc | stallreq_from_mem`
- Flush has priority over stall in every stage.

## Timing
- Reset values:
  - All FSMs are IDLE; `rp_v = 0`; `rp_pc = 0`.
  - `mcu_start` and `mcu_cancel` are 0.
  - With idle inputs, all stall and flush outputs are 0.
- Stall, flush and redirect outputs are combinational from the inputs and state; there is no added latency.
- `mcu_start` is asserted exactly once per EX instruction, in the cycle its request is first seen. It is never re-asserted while the instruction is stalled.
- A unit with `mcu_ready` already high in the start cycle still passes through BUSY, so the minimum EX occupancy of a multi-cycle instruction is 3 cycles.
- Exception in the same cycle as a start: the start is suppressed and nothing is cancelled.
- Reset mid-operation: asynchronous return to IDLE, pending redirect dropped, no cancel pulse.

## Structure
- The shared package holds the FSM state typedef (IDLE/BUSY/DONE, 2 bits), `EXC_VECTOR`, `ERET_CODE`, and the `mcu_req`/`mcu_ready` bit assignments (DIV=0, MUL=1).
- One sub-module, `mcu_seq`: a single-unit FSM, instantiated `N_MCU` times with a generate loop and a priority mask.

## Test plan
- Load-use: `ex_rmem=1`, `ex_wa=5`, `id_rs=5` → if/id stall and `ex_flush` high for 1 cycle. Repeat with `ex_wa=0` → no stall.
- Divide: `ex_mcu_req=01` with `mcu_ready` rising after 33 cycles → one `mcu_start[0]` pulse; `ex_stall` high until BUSY→DONE; the instruction advances in the DONE cycle.
- DONE with `stallreq_from_mem=1` for 4 cycles → FSM held in DONE, all stalls held, no second start.
- Exception while unit 1 is BUSY: `mem_excepttype=32'h4` → `mcu_cancel[1]` pulses, all flushes asserted, `redirect_pc=32'hBFC00380`.
- ERET (`32'hE`, `epc=32'h80001234`) with `stallreq_from_if=1` for 3 cycles → `redirect_valid` and `if_flush` held for 4 cycles, `redirect_pc=32'h80001234` throughout.
- Assert `rst` while BUSY with a redirect pending → next cycle all outputs are 0 and `rp_v=0`.
